// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with parallel load, free-run, counted burst,
// lock-up detection with optional auto-recovery, and a wrap-to-seed marker.
module lfsr_gen #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
    parameter logic [WIDTH-1:0] SEED         = 8'h01,
    parameter int               MODE         = 0,
    parameter int               CNT_W        = 8,
    parameter int               AUTO_RECOVER = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sync_init,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] po,
    output logic             serial_out,
    output logic             busy,
    output logic             done,
    output logic             lockup,
    output logic             wrap
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] po_q, po_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;
    logic             advance;
    logic [WIDTH-1:0] step_val;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        if (MODE == 0)
            return {s[WIDTH-2:0], ^(s & TAPS)};
        else
            return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? TAPS : '0);
    endfunction

    assign step_val = lfsr_step(po_q);
    assign lockup   = (po_q == '0);

    always_comb begin
        state_d = state_q;
        po_d    = po_q;
        count_d = count_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        advance = 1'b0;
        if (sync_init) begin
            po_d    = SEED;
            state_d = S_IDLE;
            count_d = '0;
        end else if (load) begin
            po_d = load_val;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            state_d = S_RUN;
                            count_d = burst_len;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else if (en) begin
                        advance = 1'b1;
                    end
                end
                S_RUN: begin
                    // A recovery edge still consumes one burst count.
                    advance = 1'b1;
                    count_d = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (lockup && (AUTO_RECOVER != 0)) begin
                po_d   = SEED;
                wrap_d = 1'b1;
            end else if (advance) begin
                po_d   = step_val;
                wrap_d = (step_val == SEED);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            po_q    <= SEED;
            count_q <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            po_q    <= po_d;
            count_q <= count_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign po         = po_q;
    assign serial_out = po_q[WIDTH-1];
    assign busy       = (state_q == S_RUN);
    assign done       = done_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: Fibonacci default, a Galois instance and a
// no-recovery instance share stimulus; expected values are hand-computed.
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sync_init = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic       en = 1'b0;
    logic       start = 1'b0;
    logic [7:0] burst_len = 8'h00;

    logic [7:0] po, g_po, n_po;
    logic       so, busy, done, lockup, wrap;
    logic       g_so, g_busy, g_done, g_lockup, g_wrap;
    logic       n_so, n_busy, n_done, n_lockup, n_wrap;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lfsr_gen u_fib (
        .clk(clk), .reset(reset), .sync_init(sync_init), .load(load), .load_val(load_val),
        .en(en), .start(start), .burst_len(burst_len), .po(po), .serial_out(so),
        .busy(busy), .done(done), .lockup(lockup), .wrap(wrap)
    );

    lfsr_gen #(.TAPS(8'h1D), .SEED(8'h80), .MODE(1)) u_gal (
        .clk(clk), .reset(reset), .sync_init(sync_init), .load(load), .load_val(load_val),
        .en(en), .start(start), .burst_len(burst_len), .po(g_po), .serial_out(g_so),
        .busy(g_busy), .done(g_done), .lockup(g_lockup), .wrap(g_wrap)
    );

    lfsr_gen #(.AUTO_RECOVER(0)) u_nr (
        .clk(clk), .reset(reset), .sync_init(sync_init), .load(load), .load_val(load_val),
        .en(en), .start(start), .burst_len(burst_len), .po(n_po), .serial_out(n_so),
        .busy(n_busy), .done(n_done), .lockup(n_lockup), .wrap(n_wrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] fib_seq [6] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};
    logic [7:0] gal_seq [3] = '{8'h1D, 8'h3A, 8'h74};
    logic [7:0] run_po  [5] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};

    initial begin
        int zero_cnt;
        int wrap_cnt;
        int busy_cnt;
        int done_cnt;

        // Reset state
        #12;
        chk("rst_po", po, 8'h01);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_lockup", lockup, 0);
        chk("rst_gal_po", g_po, 8'h80);
        chk("rst_serial", so, 0);

        reset = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pre_po", po, fib_seq[i]);
        end

        // Asynchronous reset between edges
        #3 reset = 1'b0;
        #1;
        chk("async_rst_po", po, 8'h01);
        chk("async_rst_gal", g_po, 8'h80);
        #1 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("fib_seq", po, fib_seq[i]);
            if (i < 3) chk("gal_seq", g_po, gal_seq[i]);
        end

        // Full-period free run from SEED
        sync_init = 1'b1;
        tick();
        sync_init = 1'b0;
        chk("init_po", po, 8'h01);
        chk("init_wrap", wrap, 0);
        zero_cnt = 0;
        wrap_cnt = 0;
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (po == 8'h00) zero_cnt++;
            if (wrap) wrap_cnt++;
        end
        chk("period_po", po, 8'h01);
        chk("period_wrap_now", wrap, 1);
        chk("period_wrap_cnt", wrap_cnt, 1);
        chk("period_no_zero", zero_cnt, 0);
        en = 1'b0;
        tick();
        chk("hold_po", po, 8'h01);
        chk("wrap_pulse_end", wrap, 0);

        // Burst of 5 with en asserted during RUN
        start = 1'b1;
        burst_len = 8'd5;
        en = 1'b1;
        tick();
        start = 1'b0;
        chk("burst_start_busy", busy, 1);
        chk("burst_start_po", po, 8'h01);
        busy_cnt = 1;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) en = 1'b0;
            tick();
            chk("burst_po", po, run_po[i]);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        chk("burst_done", done, 1);
        chk("burst_busy_end", busy, 0);
        tick();
        chk("burst_done_pulse", done, 0);
        chk("burst_po_hold", po, 8'h23);
        chk("burst_busy_cnt", busy_cnt, 5);
        chk("burst_done_cnt", done_cnt, 1);

        // Zero-length burst
        start = 1'b1;
        burst_len = 8'd0;
        tick();
        start = 1'b0;
        chk("zlen_done", done, 1);
        chk("zlen_busy", busy, 0);
        chk("zlen_po", po, 8'h23);
        tick();
        chk("zlen_done_end", done, 0);
        chk("zlen_po_hold", po, 8'h23);

        // Lock-up and recovery
        load = 1'b1;
        load_val = 8'h00;
        tick();
        load = 1'b0;
        chk("lock_po", po, 8'h00);
        chk("lock_flag", lockup, 1);
        chk("lock_no_wrap", wrap, 0);
        tick();
        chk("recover_po", po, 8'h01);
        chk("recover_wrap", wrap, 1);
        chk("recover_lockup", lockup, 0);
        chk("norec_po", n_po, 8'h00);
        chk("norec_lockup", n_lockup, 1);
        tick();
        chk("recover_wrap_end", wrap, 0);
        chk("norec_hold", n_po, 8'h00);

        // sync_init on third burst cycle, with a simultaneous load
        start = 1'b1;
        burst_len = 8'd10;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abort_pre_po", po, 8'h04);
        sync_init = 1'b1;
        load = 1'b1;
        load_val = 8'h55;
        tick();
        sync_init = 1'b0;
        load = 1'b0;
        chk("abort_po", po, 8'h01);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_norec_po", n_po, 8'h01);
        tick();
        chk("abort_done_late", done, 0);
        chk("abort_po_hold", po, 8'h01);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
